// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, CDB source encodings and common constants for the CDB arbiter.
// Contents: bus widths, source enum, enable/valid constants, round-robin helper.
package cdb_arbiter_pkg;

    localparam int unsigned TagBus  = 4;
    localparam int unsigned DataBus = 32;
    localparam int unsigned AddrBus = 32;
    localparam int unsigned NumSrc  = 3;

    typedef enum logic [1:0] {
        SrcALU  = 2'd0,
        SrcLS   = 2'd1,
        SrcBR   = 2'd2,
        SrcNone = 2'd3
    } cdb_src_e;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;
    localparam logic Valid   = 1'b1;
    localparam logic Invalid = 1'b0;

    // Next source in ALU -> LS -> BR -> ALU order.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : 2'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arb3.sv
// Three-request round-robin arbiter: combinational one-hot grant from the
// request bits, with a registered search pointer that moves past each grantee.
// Ports: clk, rst (sync, active-low), rdy (stall), clear (flush),
//        req_i[2:0] requests, gnt_c_o[2:0] combinational one-hot grant.
module rr_arb3
    import cdb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       clear,
    input  logic [2:0] req_i,
    output logic [2:0] gnt_c_o
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] idx;
    logic       found;

    // Search three slots starting at the pointer; first requester wins.
    always_comb begin
        gnt_c_o = '0;
        ptr_d   = ptr_q;
        idx     = ptr_q;
        found   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && req_i[idx]) begin
                gnt_c_o[idx] = 1'b1;
                ptr_d        = rr_next(idx);
                found        = 1'b1;
            end
            idx = rr_next(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= 2'd0;
        end else if (clear) begin
            ptr_q <= 2'd0;
        end else if (rdy) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: ALU, load/store and branch results each enter a
// one-entry holding register via valid/ready, and a round-robin grant picks
// one full register per cycle for a registered CDB broadcast.
// Ports: clk, rst (sync, active-low), rdy (global stall), clear (flush);
//        per source valid/tag/data (+ branch pc/jump) in, ready out;
//        cdb_valid/tag/data/pc/jump/src registered broadcast out.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned TAG_W  = TagBus,
    parameter int unsigned DATA_W = DataBus,
    parameter int unsigned ADDR_W = AddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              alu_valid_i,
    input  logic [TAG_W-1:0]  alu_tag_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              ls_valid_i,
    input  logic [TAG_W-1:0]  ls_tag_i,
    input  logic [DATA_W-1:0] ls_data_i,
    output logic              ls_ready_o,
    input  logic              br_valid_i,
    input  logic [TAG_W-1:0]  br_tag_i,
    input  logic [DATA_W-1:0] br_data_i,
    input  logic [ADDR_W-1:0] br_pc_i,
    input  logic              br_jump_i,
    output logic              br_ready_o,
    output logic              cdb_valid_o,
    output logic [TAG_W-1:0]  cdb_tag_o,
    output logic [DATA_W-1:0] cdb_data_o,
    output logic [ADDR_W-1:0] cdb_pc_o,
    output logic              cdb_jump_o,
    output logic [1:0]        cdb_src_o
);

    logic [2:0]        full_q;
    logic [2:0]        full_d;
    logic [TAG_W-1:0]  tag_q  [NumSrc];
    logic [DATA_W-1:0] data_q [NumSrc];
    logic [ADDR_W-1:0] br_pc_q;
    logic              br_jump_q;

    logic [TAG_W-1:0]  tag_in  [NumSrc];
    logic [DATA_W-1:0] data_in [NumSrc];
    logic [2:0]        valid_in;
    logic [2:0]        ready_c;
    logic [2:0]        accept_c;
    logic [2:0]        gnt_c;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
    logic [ADDR_W-1:0] cdb_pc_q,    cdb_pc_d;
    logic              cdb_jump_q,  cdb_jump_d;
    cdb_src_e          cdb_src_q,   cdb_src_d;

    assign valid_in = {br_valid_i, ls_valid_i, alu_valid_i};
    assign tag_in   = '{alu_tag_i, ls_tag_i, br_tag_i};
    assign data_in  = '{alu_data_i, ls_data_i, br_data_i};

    rr_arb3 u_rr_arb3 (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .clear   (clear),
        .req_i   (full_q),
        .gnt_c_o (gnt_c)
    );

    // A granted register drains this cycle, so it may refill at the same edge.
    always_comb begin
        ready_c = {3{Disable}};
        if (rst && rdy && !clear) begin
            ready_c = ~full_q | gnt_c;
        end
    end

    assign accept_c    = valid_in & ready_c;
    assign full_d      = (full_q & ~gnt_c) | accept_c;
    assign alu_ready_o = ready_c[0];
    assign ls_ready_o  = ready_c[1];
    assign br_ready_o  = ready_c[2];

    // Broadcast payload for the granted source; pc/jump only from branch.
    always_comb begin
        cdb_valid_d = Invalid;
        cdb_tag_d   = '0;
        cdb_data_d  = '0;
        cdb_pc_d    = '0;
        cdb_jump_d  = 1'b0;
        cdb_src_d   = SrcNone;
        if (gnt_c[0]) begin
            cdb_valid_d = Valid;
            cdb_tag_d   = tag_q[0];
            cdb_data_d  = data_q[0];
            cdb_src_d   = SrcALU;
        end else if (gnt_c[1]) begin
            cdb_valid_d = Valid;
            cdb_tag_d   = tag_q[1];
            cdb_data_d  = data_q[1];
            cdb_src_d   = SrcLS;
        end else if (gnt_c[2]) begin
            cdb_valid_d = Valid;
            cdb_tag_d   = tag_q[2];
            cdb_data_d  = data_q[2];
            cdb_pc_d    = br_pc_q;
            cdb_jump_d  = br_jump_q;
            cdb_src_d   = SrcBR;
        end
    end

    // Occupancy and broadcast state; reset beats clear beats the rdy stall.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            full_q      <= '0;
            cdb_valid_q <= Invalid;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_pc_q    <= '0;
            cdb_jump_q  <= 1'b0;
            cdb_src_q   <= SrcNone;
        end else if (rdy) begin
            full_q      <= full_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_pc_q    <= cdb_pc_d;
            cdb_jump_q  <= cdb_jump_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    // Payload storage; meaningful only while the matching full bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NumSrc); i++) begin
            if (accept_c[i]) begin
                tag_q[i]  <= tag_in[i];
                data_q[i] <= data_in[i];
            end
        end
        if (accept_c[2]) begin
            br_pc_q   <= br_pc_i;
            br_jump_q <= br_jump_i;
        end
    end

    assign cdb_valid_o = cdb_valid_q;
    assign cdb_tag_o   = cdb_tag_q;
    assign cdb_data_o  = cdb_data_q;
    assign cdb_pc_o    = cdb_pc_q;
    assign cdb_jump_o  = cdb_jump_q;
    assign cdb_src_o   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by random traffic, all
// checked against a slot/pointer reference model of the arbitration rules.
module tb_cdb_arbiter;

    localparam int unsigned TW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic clk;
    logic rst, rdy, clear;

    logic          v  [3];
    logic [TW-1:0] tg [3];
    logic [DW-1:0] dt [3];
    logic [AW-1:0] bpc;
    logic          bj;

    logic          alu_ready_o, ls_ready_o, br_ready_o;
    logic          cdb_valid_o, cdb_jump_o;
    logic [TW-1:0] cdb_tag_o;
    logic [DW-1:0] cdb_data_o;
    logic [AW-1:0] cdb_pc_o;
    logic [1:0]    cdb_src_o;

    // reference model state
    bit            m_full [3];
    logic [TW-1:0] m_tag  [3];
    logic [DW-1:0] m_data [3];
    logic [AW-1:0] m_pc;
    logic          m_jump;
    int            m_ptr;
    logic          e_valid, e_jump;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_pc;
    logic [1:0]    e_src;

    int total = 0;
    int bad   = 0;

    cdb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .clear       (clear),
        .alu_valid_i (v[0]),
        .alu_tag_i   (tg[0]),
        .alu_data_i  (dt[0]),
        .alu_ready_o (alu_ready_o),
        .ls_valid_i  (v[1]),
        .ls_tag_i    (tg[1]),
        .ls_data_i   (dt[1]),
        .ls_ready_o  (ls_ready_o),
        .br_valid_i  (v[2]),
        .br_tag_i    (tg[2]),
        .br_data_i   (dt[2]),
        .br_pc_i     (bpc),
        .br_jump_i   (bj),
        .br_ready_o  (br_ready_o),
        .cdb_valid_o (cdb_valid_o),
        .cdb_tag_o   (cdb_tag_o),
        .cdb_data_o  (cdb_data_o),
        .cdb_pc_o    (cdb_pc_o),
        .cdb_jump_o  (cdb_jump_o),
        .cdb_src_o   (cdb_src_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        int g = -1;
        for (int k = 0; k < 3; k++) begin
            int idx = (m_ptr + k) % 3;
            if (g < 0 && m_full[idx]) g = idx;
        end
        return g;
    endfunction

    task automatic model_flush();
        for (int s = 0; s < 3; s++) m_full[s] = 0;
        m_ptr   = 0;
        e_valid = 1'b0;
        e_tag   = '0;
        e_data  = '0;
        e_pc    = '0;
        e_jump  = 1'b0;
        e_src   = 2'd3;
    endtask

    // One clock: check ready before the edge, advance model, check CDB after.
    task automatic step();
        int         g;
        logic [2:0] rd;
        #1;
        g = model_grant();
        for (int s = 0; s < 3; s++)
            rd[s] = rst & rdy & ~clear & (~m_full[s] | (g == s));
        chk("ready", {61'd0, br_ready_o, ls_ready_o, alu_ready_o}, {61'd0, rd});
        @(posedge clk);
        if (!rst || clear) begin
            model_flush();
        end else if (rdy) begin
            if (g >= 0) begin
                e_valid = 1'b1;
                e_tag   = m_tag[g];
                e_data  = m_data[g];
                e_pc    = (g == 2) ? m_pc : '0;
                e_jump  = (g == 2) ? m_jump : 1'b0;
                e_src   = 2'(g);
                m_full[g] = 0;
                m_ptr     = (g + 1) % 3;
            end else begin
                e_valid = 1'b0;
                e_tag   = '0;
                e_data  = '0;
                e_pc    = '0;
                e_jump  = 1'b0;
                e_src   = 2'd3;
            end
            for (int s = 0; s < 3; s++) begin
                if (v[s] && rd[s]) begin
                    m_full[s] = 1;
                    m_tag[s]  = tg[s];
                    m_data[s] = dt[s];
                    if (s == 2) begin
                        m_pc   = bpc;
                        m_jump = bj;
                    end
                end
            end
        end
        @(negedge clk);
        chk("cdb_valid", 64'(cdb_valid_o), 64'(e_valid));
        chk("cdb_tag",   64'(cdb_tag_o),   64'(e_tag));
        chk("cdb_data",  64'(cdb_data_o),  64'(e_data));
        chk("cdb_pc",    64'(cdb_pc_o),    64'(e_pc));
        chk("cdb_jump",  64'(cdb_jump_o),  64'(e_jump));
        chk("cdb_src",   64'(cdb_src_o),   64'(e_src));
        for (int s = 0; s < 3; s++)
            if (v[s] && rd[s]) v[s] = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; clear = 1'b0;
        bpc = '0; bj = 1'b0;
        for (int s = 0; s < 3; s++) begin
            v[s] = 1'b1; tg[s] = TW'(s); dt[s] = DW'(s);
        end
        model_flush();
        @(negedge clk);

        // reset held two cycles with every source valid
        step();
        step();
        chk("rst_src", 64'(cdb_src_o), 64'd3);
        for (int s = 0; s < 3; s++) v[s] = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_ready", {61'd0, br_ready_o, ls_ready_o, alu_ready_o}, 64'd7);

        // single ALU result
        v[0] = 1'b1; tg[0] = 4'd5; dt[0] = 32'h12;
        step();
        step();
        chk("p2_valid", 64'(cdb_valid_o), 64'd1);
        chk("p2_tag",   64'(cdb_tag_o),   64'd5);
        chk("p2_data",  64'(cdb_data_o),  64'h12);
        chk("p2_src",   64'(cdb_src_o),   64'd0);
        step();
        chk("p2_idle",  64'(cdb_valid_o), 64'd0);

        // three-way contention from a fresh pointer
        rst = 1'b0; step(); rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            v[s] = 1'b1; tg[s] = TW'(s + 1); dt[s] = $urandom;
        end
        bpc = 32'h100; bj = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("p3_tag", 64'(cdb_tag_o), 64'(k + 1));
            chk("p3_src", 64'(cdb_src_o), 64'(k));
        end
        chk("p3_pc",   64'(cdb_pc_o),   64'h100);
        chk("p3_jump", 64'(cdb_jump_o), 64'd1);
        step();

        // back-to-back ALU stream
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                v[0] = 1'b1; tg[0] = TW'(i); dt[0] = $urandom;
            end
            step();
            if (i > 0) chk("p4_stream", {59'd0, cdb_valid_o, cdb_tag_o}, {59'd0, 1'b1, TW'(i - 1)});
        end
        step();

        // stall with LS full and BR waiting
        v[1] = 1'b1; tg[1] = 4'd6; dt[1] = $urandom;
        step();
        rdy = 1'b0;
        v[2] = 1'b1; tg[2] = 4'd7; dt[2] = $urandom; bpc = 32'h2000; bj = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("p5_br_ready", 64'(br_ready_o), 64'd0);
        end
        rdy = 1'b1;
        step();
        chk("p5_ls", 64'(cdb_src_o), 64'd1);
        step();
        chk("p5_br", 64'(cdb_src_o), 64'd2);
        step();

        // clear while everything is full and tag 4 is on the bus
        v[0] = 1'b1; tg[0] = 4'd4; dt[0] = $urandom;
        step();
        for (int s = 0; s < 3; s++) begin
            v[s] = 1'b1; tg[s] = TW'(10 + s); dt[s] = $urandom;
        end
        step();
        chk("p6_tag4", 64'(cdb_tag_o), 64'd4);
        clear = 1'b1;
        step();
        chk("p6_flush", 64'(cdb_valid_o), 64'd0);
        clear = 1'b0;
        for (int k = 0; k < 3; k++) step();
        v[0] = 1'b1; tg[0] = 4'd9; dt[0] = $urandom;
        step();
        step();
        chk("p6_tag9", {62'd0, cdb_src_o, 60'd0} >> 60 | 64'(cdb_tag_o), 64'd9);

        // random traffic with stalls, flushes and occasional reset
        for (int c = 0; c < 1500; c++) begin
            for (int s = 0; s < 3; s++) begin
                if (!v[s] && $urandom_range(0, 9) < 6) begin
                    v[s]  = 1'b1;
                    tg[s] = TW'($urandom);
                    dt[s] = $urandom;
                    if (s == 2) begin
                        bpc = $urandom;
                        bj  = 1'($urandom);
                    end
                end
            end
            rdy   = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
